// File: rtl/fir_decim_out.sv
// Output stage behind fastfir: decimate, round convergently, saturate to OW bits,
// and buffer in a small first-word-fall-through FIFO on a valid/ready stream.
module fir_decim_out #(
  parameter int IW     = 31,
  parameter int OW     = 16,
  parameter int SHIFT  = 15,
  parameter int NDECIM = 4,
  parameter int LGFIFO = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  input  logic          i_clr_flags,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_sat,
  output logic          o_ovfl
);

  localparam int unsigned PW    = (NDECIM > 1) ? $clog2(NDECIM) : 1;
  localparam int unsigned SW    = IW + 1 - SHIFT;
  localparam int unsigned DEPTH = 1 << LGFIFO;

  localparam logic [SHIFT-1:0] HALF = {1'b1, {(SHIFT-1){1'b0}}};
  localparam logic [SW-1:0]    MAXV = SW'((1 << (OW-1)) - 1);
  localparam logic [SW-1:0]    MINV = ~MAXV;

  logic [PW-1:0]     phase;
  logic              v1, v2;
  logic [SW-1:0]     q1;
  logic [OW-1:0]     data2;
  logic              carry;
  logic              sat_hi, sat_lo, sat_evt;

  logic [LGFIFO:0]   wptr, rptr;
  logic [OW-1:0]     mem [DEPTH];
  logic [OW-1:0]     hold;
  logic              empty, full, pop, push, drop;

  // Only the kept bits of (sample + 2^(SHIFT-1)-1 + lsb) are stored; the carry out
  // of the discarded bits reduces to a compare against one half, biased by the kept lsb.
  always_comb begin
    carry = i_sample[SHIFT] ? (i_sample[SHIFT-1:0] >= HALF)
                            : (i_sample[SHIFT-1:0] >  HALF);
  end

  always_comb begin
    sat_hi  = $signed(q1) > $signed(MAXV);
    sat_lo  = $signed(q1) < $signed(MINV);
    sat_evt = v1 & (sat_hi | sat_lo);
  end

  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[LGFIFO] != rptr[LGFIFO]) &&
              (wptr[LGFIFO-1:0] == rptr[LGFIFO-1:0]);
    o_valid = ~empty;
    pop     = o_valid & i_ready;
    push    = v2 & (~full | pop);
    drop    = v2 & full & ~pop;
    o_data  = empty ? hold : mem[rptr[LGFIFO-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase  <= '0;
      v1     <= 1'b0;
      q1     <= '0;
      v2     <= 1'b0;
      data2  <= '0;
      wptr   <= '0;
      rptr   <= '0;
      hold   <= '0;
      o_sat  <= 1'b0;
      o_ovfl <= 1'b0;
    end else begin
      v1 <= i_ce && (phase == '0);
      if (i_ce) begin
        phase <= (phase == PW'(NDECIM - 1)) ? '0 : phase + PW'(1);
        q1    <= {i_sample[IW-1], i_sample[IW-1:SHIFT]} + SW'(carry);
      end

      v2 <= v1;
      if (sat_hi)      data2 <= MAXV[OW-1:0];
      else if (sat_lo) data2 <= MINV[OW-1:0];
      else             data2 <= q1[OW-1:0];

      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        hold <= mem[rptr[LGFIFO-1:0]];
      end

      if (sat_evt)          o_sat <= 1'b1;
      else if (i_clr_flags) o_sat <= 1'b0;

      if (drop)             o_ovfl <= 1'b1;
      else if (i_clr_flags) o_ovfl <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[LGFIFO-1:0]] <= data2;
  end

endmodule
